// File: rtl/cc_pwm_timebase_pkg.sv
// rtl/cc_pwm_timebase_pkg.sv - shared state encoding and default sizes for the PWM timebase
//
// Purpose : single home for the timebase FSM encoding and the default bus,
//           prescaler width and divider constants used by the interface,
//           the prescaler and the top.
// Ports   : none (package).

package cc_pwm_timebase_pkg;

  // Run-state of the timebase. STOPPING keeps counting until the current
  // period finishes so the PWM output is never cut short mid-period.
  typedef enum logic [1:0] {
    CC_IDLE     = 2'd0,
    CC_RUN      = 2'd1,
    CC_STOPPING = 2'd2
  } ccPwmState_t;

  localparam int CC_DEFAULT_DATAWIDTH         = 8;
  localparam int CC_DEFAULT_PRESCALER_WIDTH   = 16;
  // 50 clocks per tick gives a 1 MHz tick from the 50 MHz system clock.
  localparam int CC_DEFAULT_PRESCALER_DIVIDER = 50;

endpackage

// File: rtl/cc_pwm_timebase_if.sv
// rtl/cc_pwm_timebase_if.sv - control/observation bundle between the PWM timebase and its user
//
// Purpose : groups the run/load controls, the requested duty/period and the
//           comparator-facing outputs of cc_pwm_timebase.
// Ports   : none; signals
//   CC_PWMTIMEBASE_enable_In        run request (level)
//   CC_PWMTIMEBASE_load_In          one-cycle strobe, captures duty/period into shadow
//   CC_PWMTIMEBASE_duty_InBUS       requested high time in ticks
//   CC_PWMTIMEBASE_period_InBUS     requested period P (period lasts P+1 ticks)
//   CC_PWMTIMEBASE_count_OutBUS     counter, comparator A
//   CC_PWMTIMEBASE_duty_OutBUS      committed threshold, comparator B
//   CC_PWMTIMEBASE_zeroDuty_Out     committed duty is 0
//   CC_PWMTIMEBASE_periodStart_Out  one-cycle pulse at each period start
//   CC_PWMTIMEBASE_loadAck_Out      one-cycle pulse when the shadow is committed
//   CC_PWMTIMEBASE_pending_Out      shadow value waiting for commit
//   CC_PWMTIMEBASE_running_Out      timebase in RUN or STOPPING
// Modports: master = controller side, slave = timebase side.

interface cc_pwm_timebase_if
  import cc_pwm_timebase_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH = CC_DEFAULT_DATAWIDTH
);

  logic                        CC_PWMTIMEBASE_enable_In;
  logic                        CC_PWMTIMEBASE_load_In;
  logic [NUMBER_DATAWIDTH-1:0] CC_PWMTIMEBASE_duty_InBUS;
  logic [NUMBER_DATAWIDTH-1:0] CC_PWMTIMEBASE_period_InBUS;
  logic [NUMBER_DATAWIDTH-1:0] CC_PWMTIMEBASE_count_OutBUS;
  logic [NUMBER_DATAWIDTH-1:0] CC_PWMTIMEBASE_duty_OutBUS;
  logic                        CC_PWMTIMEBASE_zeroDuty_Out;
  logic                        CC_PWMTIMEBASE_periodStart_Out;
  logic                        CC_PWMTIMEBASE_loadAck_Out;
  logic                        CC_PWMTIMEBASE_pending_Out;
  logic                        CC_PWMTIMEBASE_running_Out;

  modport master (
    output CC_PWMTIMEBASE_enable_In,
    output CC_PWMTIMEBASE_load_In,
    output CC_PWMTIMEBASE_duty_InBUS,
    output CC_PWMTIMEBASE_period_InBUS,
    input  CC_PWMTIMEBASE_count_OutBUS,
    input  CC_PWMTIMEBASE_duty_OutBUS,
    input  CC_PWMTIMEBASE_zeroDuty_Out,
    input  CC_PWMTIMEBASE_periodStart_Out,
    input  CC_PWMTIMEBASE_loadAck_Out,
    input  CC_PWMTIMEBASE_pending_Out,
    input  CC_PWMTIMEBASE_running_Out
  );

  modport slave (
    input  CC_PWMTIMEBASE_enable_In,
    input  CC_PWMTIMEBASE_load_In,
    input  CC_PWMTIMEBASE_duty_InBUS,
    input  CC_PWMTIMEBASE_period_InBUS,
    output CC_PWMTIMEBASE_count_OutBUS,
    output CC_PWMTIMEBASE_duty_OutBUS,
    output CC_PWMTIMEBASE_zeroDuty_Out,
    output CC_PWMTIMEBASE_periodStart_Out,
    output CC_PWMTIMEBASE_loadAck_Out,
    output CC_PWMTIMEBASE_pending_Out,
    output CC_PWMTIMEBASE_running_Out
  );

endinterface

// File: rtl/cc_pwm_prescaler.sv
// rtl/cc_pwm_prescaler.sv - tick generator dividing the system clock for the PWM counter
//
// Purpose : counts 0..PRESCALER_DIVIDER-1 while run is high and flags the
//           last count as the counter tick; held at 0 while run is low so
//           every run starts with a full-length first tick.
// Ports   :
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   run   in   timebase is RUN or STOPPING
//   tick  out  high on the cycle the prescaler sits at DIVIDER-1

module cc_pwm_prescaler
  import cc_pwm_timebase_pkg::*;
#(
  parameter int PRESCALER_WIDTH   = CC_DEFAULT_PRESCALER_WIDTH,
  parameter int PRESCALER_DIVIDER = CC_DEFAULT_PRESCALER_DIVIDER
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam logic [PRESCALER_WIDTH-1:0] LAST_COUNT = PRESCALER_WIDTH'(PRESCALER_DIVIDER - 1);

  logic [PRESCALER_WIDTH-1:0] preCount;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preCount <= '0;
    end else if (!run || (preCount == LAST_COUNT)) begin
      preCount <= '0;
    end else begin
      preCount <= preCount + PRESCALER_WIDTH'(1);
    end
  end

  // With a divider of 1 LAST_COUNT is 0, so tick stays high for every run cycle.
  assign tick = run && (preCount == LAST_COUNT);

endmodule

// File: rtl/cc_pwm_timebase.sv
// rtl/cc_pwm_timebase.sv - PWM timebase with duty/period shadow committed on period boundaries
//
// Purpose : prescaled up-counter (comparator A) and committed duty threshold
//           (comparator B). Duty/period loads land in a shadow and become
//           active only at a period start, so the PWM never glitches. A
//           requested duty D is encoded as threshold D-1 (A <= B gives D high
//           ticks), clamped to P for 100 %, with D=0 flagged on zeroDuty.
// Ports   :
//   CC_PWMTIMEBASE_CLOCK_50      in  system clock, rising edge
//   CC_PWMTIMEBASE_RESET_InHigh  in  asynchronous active-high reset
//   pwmBus                       slave modport of cc_pwm_timebase_if
//                                (controls in, registered counter/threshold/status out)

module cc_pwm_timebase
  import cc_pwm_timebase_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH  = CC_DEFAULT_DATAWIDTH,
  parameter int PRESCALER_WIDTH   = CC_DEFAULT_PRESCALER_WIDTH,
  parameter int PRESCALER_DIVIDER = CC_DEFAULT_PRESCALER_DIVIDER
) (
  input  logic             CC_PWMTIMEBASE_CLOCK_50,
  input  logic             CC_PWMTIMEBASE_RESET_InHigh,
  cc_pwm_timebase_if.slave pwmBus
);

  localparam int W = NUMBER_DATAWIDTH;

  typedef struct packed {
    logic         zero;
    logic [W-1:0] threshold;
  } dutyCode_t;

  // Threshold for the A <= B comparator. The clamp is judged against the
  // period that is committed together with this duty, not the active one.
  function automatic dutyCode_t encodeDuty(input logic [W-1:0] reqDuty,
                                           input logic [W-1:0] reqPeriod);
    dutyCode_t    code;
    logic [W-1:0] dutyMinusOne;
    dutyMinusOne = reqDuty - W'(1);
    code.zero    = (reqDuty == '0);
    if (reqDuty == '0) begin
      code.threshold = '0;
    end else if (dutyMinusOne > reqPeriod) begin
      code.threshold = reqPeriod;
    end else begin
      code.threshold = dutyMinusOne;
    end
    return code;
  endfunction

  ccPwmState_t  state;
  logic [W-1:0] count;
  logic [W-1:0] committedPeriod;
  logic [W-1:0] dutyReg;
  logic         zeroDutyReg;
  logic [W-1:0] shadowDuty;
  logic [W-1:0] shadowPeriod;
  logic         pendingReg;
  logic         periodStartReg;
  logic         loadAckReg;
  logic         runningReg;

  logic         enable;
  logic         load;
  logic         active;
  logic         tick;
  logic         wrap;
  logic         startFromIdle;
  logic         stopAtWrap;
  logic         periodBegins;
  logic         commitNow;
  dutyCode_t    shadowCode;

  assign enable = pwmBus.CC_PWMTIMEBASE_enable_In;
  assign load   = pwmBus.CC_PWMTIMEBASE_load_In;
  assign active = (state != CC_IDLE);

  cc_pwm_prescaler #(
    .PRESCALER_WIDTH  (PRESCALER_WIDTH),
    .PRESCALER_DIVIDER(PRESCALER_DIVIDER)
  ) prescaler (
    .clk (CC_PWMTIMEBASE_CLOCK_50),
    .rst (CC_PWMTIMEBASE_RESET_InHigh),
    .run (active),
    .tick(tick)
  );

  // A wrap that ends a STOPPING period goes back to IDLE instead of starting
  // a new period: no periodStart pulse, and any pending shadow waits for
  // the next IDLE->RUN start.
  assign wrap          = tick && (count == committedPeriod);
  assign startFromIdle = (state == CC_IDLE) && enable;
  assign stopAtWrap    = (state == CC_STOPPING) && !enable && wrap;
  assign periodBegins  = startFromIdle || (wrap && !stopAtWrap);
  assign commitNow     = periodBegins && pendingReg;
  assign shadowCode    = encodeDuty(shadowDuty, shadowPeriod);

  always_ff @(posedge CC_PWMTIMEBASE_CLOCK_50 or posedge CC_PWMTIMEBASE_RESET_InHigh) begin
    if (CC_PWMTIMEBASE_RESET_InHigh) begin
      state           <= CC_IDLE;
      count           <= '0;
      committedPeriod <= '1;
      dutyReg         <= '0;
      zeroDutyReg     <= 1'b1;
      shadowDuty      <= '0;
      shadowPeriod    <= '1;
      pendingReg      <= 1'b0;
      periodStartReg  <= 1'b0;
      loadAckReg      <= 1'b0;
      runningReg      <= 1'b0;
    end else begin
      periodStartReg <= periodBegins;
      loadAckReg     <= commitNow;

      case (state)
        CC_IDLE: begin
          if (enable) begin
            state      <= CC_RUN;
            runningReg <= 1'b1;
          end
        end
        CC_RUN: begin
          if (!enable) begin
            state <= CC_STOPPING;
          end
        end
        CC_STOPPING: begin
          // Re-enable resumes in place; the count is never restarted.
          if (enable) begin
            state <= CC_RUN;
          end else if (wrap) begin
            state      <= CC_IDLE;
            runningReg <= 1'b0;
          end
        end
        default: begin
          state      <= CC_IDLE;
          runningReg <= 1'b0;
        end
      endcase

      if (startFromIdle || wrap) begin
        count <= '0;
      end else if (tick) begin
        count <= count + W'(1);
      end

      if (commitNow) begin
        committedPeriod <= shadowPeriod;
        dutyReg         <= shadowCode.threshold;
        zeroDutyReg     <= shadowCode.zero;
        pendingReg      <= 1'b0;
      end

      // Placed after the commit so a load on a boundary edge commits the
      // older shadow first and leaves the new value pending.
      if (load) begin
        shadowDuty   <= pwmBus.CC_PWMTIMEBASE_duty_InBUS;
        shadowPeriod <= pwmBus.CC_PWMTIMEBASE_period_InBUS;
        pendingReg   <= 1'b1;
      end
    end
  end

  assign pwmBus.CC_PWMTIMEBASE_count_OutBUS    = count;
  assign pwmBus.CC_PWMTIMEBASE_duty_OutBUS     = dutyReg;
  assign pwmBus.CC_PWMTIMEBASE_zeroDuty_Out    = zeroDutyReg;
  assign pwmBus.CC_PWMTIMEBASE_periodStart_Out = periodStartReg;
  assign pwmBus.CC_PWMTIMEBASE_loadAck_Out     = loadAckReg;
  assign pwmBus.CC_PWMTIMEBASE_pending_Out     = pendingReg;
  assign pwmBus.CC_PWMTIMEBASE_running_Out     = runningReg;

endmodule

// File: doc/cc_pwm_timebase.md
# cc_pwm_timebase

PWM timebase and duty-shadow stage that drives the greater-than comparator in the motor PWM path. It generates a prescaled up-counter (comparator A input) and a committed duty threshold (comparator B input). New duty and period values are accepted at any time through a load strobe and are committed only at a period boundary, so the PWM output never glitches. The comparator's "A ≤ B → 1" output becomes the PWM level; this block also flags the 0 % duty case, which the comparator cannot express.

## Interface
- NUMBER_DATAWIDTH, 8: width of the counter, duty and period buses.
- PRESCALER_WIDTH, 16: width of the prescaler counter.
- PRESCALER_DIVIDER, 50: clocks per counter tick, ≥1 (50 gives a 1 MHz tick at 50 MHz).
- CC_PWMTIMEBASE_CLOCK_50  in  1  system clock, rising edge.
- CC_PWMTIMEBASE_RESET_InHigh  in  1  reset; one clock, asynchronous, active-high.
- CC_PWMTIMEBASE_enable_In  in  1  level; run request.
- CC_PWMTIMEBASE_load_In  in  1  one-cycle strobe; captures the duty and period inputs into the shadow registers.
- CC_PWMTIMEBASE_duty_InBUS  in  W  requested high time, in ticks.
- CC_PWMTIMEBASE_period_InBUS  in  W  requested period P; the period lasts P+1 ticks.
- CC_PWMTIMEBASE_count_OutBUS  out  W  counter, to comparator A.
- CC_PWMTIMEBASE_duty_OutBUS  out  W  committed threshold, to comparator B.
- CC_PWMTIMEBASE_zeroDuty_Out  out  1  committed duty is 0; downstream forces PWM low.
- CC_PWMTIMEBASE_periodStart_Out  out  1  one-cycle pulse at each period start.
- CC_PWMTIMEBASE_loadAck_Out  out  1  one-cycle pulse when a shadow value is committed.
- CC_PWMTIMEBASE_pending_Out  out  1  a shadow value is waiting to be committed.
- CC_PWMTIMEBASE_running_Out  out  1  high in RUN or STOPPING.

## Operation
- FSM states:
  - IDLE → RUN when enable_In=1.
  - RUN → STOPPING when enable_In=0.
  - STOPPING → RUN when enable_In=1. This happens with no interruption: the count continues.
  - STOPPING → IDLE on wrap.
- IDLE behaviour: count, prescaler and pulse outputs are held at 0.
- Prescaler and tick:
  - The prescaler counts 0..DIVIDER-1 while in RUN or STOPPING.
  - The tick occurs on the cycle the prescaler equals DIVIDER-1.
- Counter:
  - On tick, count increments.
  - On tick with count == committed P, count wraps to 0.
- Entering RUN from IDLE:
  - count=0 and prescaler=0.
  - Any pending shadow value is committed.
  - periodStart_Out pulses, plus loadAck_Out if a commit occurred.
- Commit at wrap:
  - If pending_Out=1, the shadow duty and period become active, loadAck_Out pulses, and pending clears.
- Duty encoding (requested duty D, committed P):
  - D=0 → zeroDuty_Out=1 and duty_OutBUS=0.
  - 1 ≤ D ≤ P+1 → duty_OutBUS=D-1, giving D high ticks per period.
  - D > P+1 → clamp duty_OutBUS to P, i.e. 100 %.
  - The clamp is evaluated at commit time against the P being committed.
- Load rules:
  - load_In in any state captures the inputs into shadow and sets pending.
  - A second load before commit overwrites the shadow; only one ack is produced.
- Load in the same cycle as a wrap:
  - Any previously pending value commits at this wrap.
  - The new value is captured and stays pending until the next wrap.
- Load in the same cycle as IDLE→RUN: same rule as a load coinciding with a wrap.
- Reset mid-operation:
  - All registers return to their reset values immediately, asynchronously.
  - Any pending load is discarded.

## Timing
- Reset values:
  - count_OutBUS=0, duty_OutBUS=0 and zeroDuty_Out=1.
  - Committed P = all ones.
  - periodStart_Out=0, loadAck_Out=0, pending_Out=0 and running_Out=0.
  - FSM in IDLE.
- All outputs are registered, so zero combinational paths run from inputs to outputs.
- IDLE→RUN:
  - enable_In is sampled high at edge n.
  - running_Out=1, periodStart_Out=1 and count=0 are visible after edge n.
- Count cadence: count advances every DIVIDER clocks, so a full period lasts (P+1)·DIVIDER clocks.
- Wrap edge:
  - count becomes 0, the new duty and P are visible, and periodStart_Out and loadAck_Out are high for exactly that cycle.
- pending_Out timing: rises the cycle after load_In and falls on the commit edge.

## Structure
- Shared package:
  - FSM state encoding (IDLE, RUN, STOPPING).
  - Default DIVIDER and width constants.
- Natural sub-module: cc_pwm_prescaler (tick generator).
- The shadow/commit logic and duty clamp stay in the top.

## Test plan
Simulate with W=8, DIVIDER=2.
- Reset, then enable with no load:
  - Count runs 0..255, one tick every 2 clocks.
  - duty_OutBUS=0 and zeroDuty_Out=1.
- Load D=3, P=9 while IDLE, then enable:
  - Commit at start: loadAck_Out and periodStart_Out pulse, duty_OutBUS=2.
  - Count wraps 9→0 every 20 clocks.
- While running with P=9, load D=5 mid-period:
  - pending_Out=1 until the wrap.
  - duty_OutBUS changes 2→4 exactly on the wrap edge.
- Load D=20 with P=9:
  - Committed duty_OutBUS=9 (clamp) and zeroDuty_Out=0.
- Two loads before a wrap (D=1, then D=7):
  - One loadAck_Out pulse; committed duty_OutBUS=6.
- Drop enable at count=4:
  - Counting continues to 9, then IDLE with count=0 and running_Out=0.
- Assert reset at count=6 with a load pending:
  - All outputs take their reset values immediately and pending_Out=0.
